// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the EX-stage divider
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // All-ones quotient on divide-by-zero; callers truncate to their width.
  localparam logic [63:0] DIV0_QUO = '1;

endpackage

// File: rtl/ex_div_unit_if.sv
// rtl/ex_div_unit_if.sv - pipeline-to-divider handshake and result bundle
interface ex_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             isSigned;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             advance;
  logic             cancel;
  logic             EX_requireStall;
  logic             busy;
  logic             resultValid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, isSigned, dividend, divisor, advance, cancel,
    input  EX_requireStall, busy, resultValid, quotient, remainder
  );

  modport slave (
    input  start, isSigned, dividend, divisor, advance, cancel,
    output EX_requireStall, busy, resultValid, quotient, remainder
  );

endinterface

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational restoring-division iteration
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   cand;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Shifted partial remainder needs one extra bit; the difference never does.
  assign cand  = {rem_i, quo_i[WIDTH-1]};
  assign fits  = cand >= {1'b0, divisor_i};
  assign diff  = cand[WIDTH-1:0] - divisor_i;
  assign rem_o = fits ? diff : cand[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - iterative radix-2 restoring DIV/DIVU unit for the EX stage
module ex_div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_div_unit_if.slave dif
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] dividend_abs, divisor_abs;
  logic             dividend_neg, divisor_neg;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign dividend_neg = dif.isSigned && dif.dividend[WIDTH-1];
  assign divisor_neg  = dif.isSigned && dif.divisor[WIDTH-1];
  assign dividend_abs = dividend_neg ? -dif.dividend : dif.dividend;
  assign divisor_abs  = divisor_neg ? -dif.divisor : dif.divisor;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    valid_d     = valid_q;

    if (dif.cancel) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dif.start) begin
            rem_d  = '0;
            quo_d  = dividend_abs;
            dvsr_d = divisor_abs;
            qneg_d = dividend_neg ^ divisor_neg;
            rneg_d = dividend_neg;
            cnt_d  = '0;
            if (dif.divisor == '0) begin
              quotient_d  = WIDTH'(DIV0_QUO);
              remainder_d = dif.dividend;
              valid_d     = 1'b1;
              state_d     = DONE;
            end else begin
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quotient_d  = qneg_q ? -step_quo : step_quo;
            remainder_d = rneg_q ? -step_rem : step_rem;
            valid_d     = 1'b1;
            state_d     = DONE;
          end
        end
        DONE: begin
          // start stays high while this instruction is still parked in EX.
          if (dif.advance) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
    end
  end

  assign dif.EX_requireStall = !dif.cancel &&
                               (((state_q == IDLE) && dif.start) || (state_q == BUSY));
  assign dif.busy            = (state_q != IDLE);
  assign dif.resultValid     = valid_q;
  assign dif.quotient        = quotient_q;
  assign dif.remainder       = remainder_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - directed self-checking bench for ex_div_unit
module tb_ex_div_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ex_div_unit_if #(.WIDTH(32)) dif ();

  ex_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name, input logic [31:0] q, input logic [31:0] r);
    checks++;
    if ({dif.busy, dif.resultValid, dif.EX_requireStall} !== 3'b000) begin
      failures++;
      $display("FAIL %s flags busy/valid/stall=%b%b%b expected 000", name,
               dif.busy, dif.resultValid, dif.EX_requireStall);
    end
    checks++;
    if (dif.quotient !== q || dif.remainder !== r) begin
      failures++;
      $display("FAIL %s q=%h r=%h expected q=%h r=%h", name, dif.quotient, dif.remainder, q, r);
    end
  endtask

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input int ecyc);
    int cyc;
    int stalls;
    dif.isSigned = sgn;
    dif.dividend = a;
    dif.divisor  = b;
    dif.advance  = 1'b1;
    dif.cancel   = 1'b0;
    dif.start    = 1'b1;
    #1;
    cyc    = 0;
    stalls = 0;
    while (!dif.resultValid && cyc < 100) begin
      if (dif.EX_requireStall) stalls++;
      tick();
      cyc++;
    end
    dif.start = 1'b0;
    checks++;
    if (cyc !== ecyc) begin
      failures++;
      $display("FAIL %s latency=%0d expected %0d", name, cyc, ecyc);
    end
    checks++;
    if (stalls !== ecyc || dif.EX_requireStall !== 1'b0) begin
      failures++;
      $display("FAIL %s stall cycles=%0d stall_in_done=%b expected %0d and 0", name, stalls,
               dif.EX_requireStall, ecyc);
    end
    checks++;
    if (dif.quotient !== eq || dif.remainder !== er) begin
      failures++;
      $display("FAIL %s q=%h r=%h expected q=%h r=%h", name, dif.quotient, dif.remainder, eq, er);
    end
    tick();
    checks++;
    if (dif.busy !== 1'b0 || dif.resultValid !== 1'b0) begin
      failures++;
      $display("FAIL %s after_advance busy=%b valid=%b expected 0 0", name, dif.busy,
               dif.resultValid);
    end
  endtask

  task automatic test_reset();
    dif.start    = 1'b0;
    dif.isSigned = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    dif.advance  = 1'b0;
    dif.cancel   = 1'b0;
    rst_n        = 1'b0;
    #12;
    check_idle_outputs("reset", 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("udiv_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33);
  endtask

  task automatic test_signed();
    run_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    run_div("sdiv_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33);
  endtask

  task automatic test_div_zero();
    run_div("udiv_by_zero", 1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1);
    run_div("sdiv_by_zero", 1'b1, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);
  endtask

  task automatic test_hold_done();
    int cyc;
    int bad;
    dif.isSigned = 1'b0;
    dif.dividend = 32'd50;
    dif.divisor  = 32'd6;
    dif.advance  = 1'b0;
    dif.cancel   = 1'b0;
    dif.start    = 1'b1;
    #1;
    cyc = 0;
    while (!dif.resultValid && cyc < 100) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 33) begin
      failures++;
      $display("FAIL hold_latency latency=%0d expected 33", cyc);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (dif.quotient !== 32'd8 || dif.remainder !== 32'd2 || dif.EX_requireStall !== 1'b0 ||
          dif.resultValid !== 1'b1 || dif.busy !== 1'b1)
        bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold_done bad_cycles=%0d expected 0 (q=%h r=%h stall=%b)", bad,
               dif.quotient, dif.remainder, dif.EX_requireStall);
    end
    dif.advance = 1'b1;
    dif.start   = 1'b0;
    tick();
    check_idle_outputs("hold_release", 32'd8, 32'd2);
  endtask

  task automatic test_cancel();
    int seen_valid;
    dif.isSigned = 1'b0;
    dif.dividend = 32'd1000;
    dif.divisor  = 32'd3;
    dif.advance  = 1'b1;
    dif.cancel   = 1'b0;
    dif.start    = 1'b1;
    seen_valid   = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dif.resultValid) seen_valid++;
    end
    dif.cancel = 1'b1;
    #1;
    checks++;
    if (dif.EX_requireStall !== 1'b0 || dif.busy !== 1'b1) begin
      failures++;
      $display("FAIL cancel_stall stall=%b busy=%b expected 0 1", dif.EX_requireStall, dif.busy);
    end
    tick();
    dif.cancel = 1'b0;
    dif.start  = 1'b0;
    if (dif.resultValid) seen_valid++;
    checks++;
    if (dif.busy !== 1'b0 || seen_valid !== 0) begin
      failures++;
      $display("FAIL cancel_idle busy=%b valid_cycles=%0d expected 0 0", dif.busy, seen_valid);
    end
    run_div("after_cancel_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
  endtask

  task automatic test_async_reset();
    dif.isSigned = 1'b0;
    dif.dividend = 32'd12345;
    dif.divisor  = 32'd10;
    dif.advance  = 1'b1;
    dif.cancel   = 1'b0;
    dif.start    = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    #2;
    dif.start = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_idle_outputs("async_reset", 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_div("after_reset_12345_10", 1'b0, 32'd12345, 32'd10, 32'd1234, 32'd5, 33);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_hold_done();
    test_cancel();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
Iterative radix-2 restoring divider in the EX stage for DIV/DIVU.
- Raises EX_requireStall to the pipeline controller for the whole divide, which holds the instruction in EX and bubbles MEM.
- Presents the quotient (LO) and remainder (HI) once the divide completes.
- Holds the result while the downstream stages stall, then returns to idle.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, $clog2(WIDTH)+1, iteration counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  divide instruction valid in EX (held high while the instruction sits in EX)
isSigned  input  1  1 = DIV, 0 = DIVU; sampled with start in IDLE
dividend  input  WIDTH  rs operand; sampled with start in IDLE
divisor  input  WIDTH  rt operand; sampled with start in IDLE
advance  input  1  EX may hand off to MEM this cycle (= !EX_MEM_stall)
cancel  input  1  instruction in EX squashed (exception/redirect)
EX_requireStall  output  1  stall request to the pipeline controller
busy  output  1  state != IDLE
resultValid  output  1  quotient/remainder valid
quotient  output  WIDTH  LO result
remainder  output  WIDTH  HI result

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, all working registers 0, quotient=0, remainder=0, resultValid=0, busy=0, EX_requireStall=0.
- States: IDLE, BUSY, DONE (encoding from the package).
- IDLE, start=1, cancel=0:
  - Latch |dividend| and |divisor| (absolute values only when isSigned).
  - Latch quotient-sign = sign(dividend) XOR sign(divisor), and remainder-sign = sign(dividend).
  - Clear the counter.
  - Go to BUSY, or to DONE directly if divisor==0.
- BUSY: one restoring step per cycle.
  - Shift {rem,quo} left 1.
  - Trial subtract the divisor (WIDTH+1-bit arithmetic); if non-negative, keep the difference and set the quo LSB.
  - Counter increments each step.
  - On the WIDTH-th step, the sign-corrected results are registered and the state goes to DONE.
- Sign correction: negate the quotient if quotient-sign; negate the remainder if remainder-sign; two's complement, truncated to WIDTH.
  - -2^(WIDTH-1) / -1 yields quotient 0x80000000, remainder 0; no trap.
- Divide by zero: quotient = all ones, remainder = the original dividend (signed or unsigned alike).
- DONE:
  - resultValid=1; quotient and remainder held stable.
  - start is ignored; no restart while the same instruction remains in EX.
  - advance=1: go to IDLE next cycle and clear resultValid.
  - advance=0: stay in DONE.
- EX_requireStall (combinational) = !cancel && ((state==IDLE && start) || state==BUSY).
  - Normal divide: high in the start cycle (cycle 0) and BUSY cycles 1..WIDTH, i.e. 33 cycles at WIDTH=32; low in DONE (cycle 33).
  - Divide by zero: high for cycle 0 only; DONE at cycle 1.
- cancel=1 (synchronous) in any state:
  - Go to IDLE next cycle and clear resultValid.
  - EX_requireStall forced low in that same cycle.
  - cancel has priority over start and advance.
- start dropping in BUSY (without cancel) is a protocol violation; the divide continues to DONE.
- Back-to-back divides: the second start is sampled in the cycle after DONE+advance, when the state is IDLE.
- No internal X propagation: all registers have reset values.

Decomposition:
- Package div_pkg:
  - state encoding localparams (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - divide-by-zero quotient constant;
  - WIDTH default.
- Sub-module div_iter_step:
  - combinational single restoring iteration;
  - in: rem, quo, divisor;
  - out: next rem, next quo.
- Sign handling and the FSM stay in ex_div_unit.

Test Plan:
1. Unsigned 100/7 (isSigned=0, advance=1):
   - EX_requireStall high cycles 0..32;
   - cycle 33: resultValid=1, quotient=14, remainder=2;
   - IDLE at cycle 34.
2. Signed -7/2:
   - quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
   - Signed 0x80000000/0xFFFFFFFF gives quotient=0x80000000, remainder=0.
3. Divisor 0, dividend 0x1234:
   - EX_requireStall high 1 cycle only;
   - cycle 1: quotient=0xFFFFFFFF, remainder=0x1234.
4. Hold in DONE with start high and advance=0 for 5 cycles:
   - quotient/remainder stable, EX_requireStall stays 0, no restart;
   - advance=1, then IDLE next cycle.
5. cancel=1 at BUSY cycle 10:
   - EX_requireStall low that cycle; IDLE next cycle; resultValid never asserted.
   - A new 9/3 divide afterwards gives quotient=3, remainder=0.
6. rst_n pulsed low mid-BUSY (cycle 15), asynchronously off the clock edge:
   - all outputs 0 immediately;
   - a fresh divide after release completes correctly.
